peripheral_uart_tfifo_wb: RTL



---
 rtl/peripheral_uart_tfifo_wb.sv | 116 +++++++++++
 1 files changed

// File: rtl/peripheral_uart_tfifo_wb.sv
// Transmit FIFO controller for the WishBone UART: pointers, occupancy and
// overflow status around a dual-port RAM with an asynchronous read port.

module peripheral_raminfr_wb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [ADDR_WIDTH-1:0] dpra,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dpo
);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      ram[a] <= di;
  end

  // Asynchronous read lets the head entry appear without a pipeline bubble.
  assign dpo = ram[dpra];

endmodule

module peripheral_uart_tfifo_wb #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   fifo_reset,
  input  logic                   reset_status,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  logic [ADDR_WIDTH-1:0] top;
  logic [ADDR_WIDTH-1:0] bottom;
  logic [DATA_WIDTH-1:0] ramData;
  logic                  writeEn;
  logic                  dropPush;

  assign empty = (count == '0);
  assign full  = (count == COUNT_WIDTH'(DEPTH));

  // A push is accepted unless flushing, or full without a matching pop.
  assign writeEn  = push && !fifo_reset && (pop || !full);
  assign dropPush = push && !pop && full && !fifo_reset;

  peripheral_raminfr_wb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (writeEn),
    .a    (top),
    .dpra (bottom),
    .di   (data_in),
    .dpo  (ramData)
  );

  assign data_out = empty ? '0 : ramData;

  // Pointer/count update; a push+pop on an empty FIFO behaves as a push only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top    <= '0;
      bottom <= '0;
      count  <= '0;
    end else if (fifo_reset) begin
      top    <= '0;
      bottom <= '0;
      count  <= '0;
    end else if (push && pop) begin
      top <= top + ADDR_WIDTH'(1);
      if (empty)
        count <= COUNT_WIDTH'(1);
      else
        bottom <= bottom + ADDR_WIDTH'(1);
    end else if (push) begin
      if (!full) begin
        top   <= top + ADDR_WIDTH'(1);
        count <= count + COUNT_WIDTH'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        bottom <= bottom + ADDR_WIDTH'(1);
        count  <= count - COUNT_WIDTH'(1);
      end
    end
  end

  // Sticky overflow; a dropped push outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (dropPush)
      overflow <= 1'b1;
    else if (reset_status)
      overflow <= 1'b0;
  end

endmodule
